orbit_integrator_fx: RTL and testbench
======================================

// Module: orbit_integrator_fx
// PURPOSE
//  Time-multiplexed fixed-point two-body orbit integrator for N_CH independent bodies around a central mass.
//  Uses semi-implicit Euler: v += a*DT, then p += v_new*DT, with a = -GM*p/|p|^3.
//  One shared multiplier, one iterative square root and one iterative divider serve all channels.
//  Feeds the trajectory plotting / VGA path with per-body X,Y samples once per step.
// PARAMETERS
//  W      32          signed word width of all state and outputs
//  F      16          fractional bits (Q(W-F).F, two's complement)
//  N_CH   4           number of bodies, >=1; channel index width CW = max(1,$clog2(N_CH))
//  GM     32'h00010000  gravitational parameter, Q format, W bits
//  DT     32'h00000400  time step, Q format, W bits (default 1/64)
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  init_we    in   1   write one state word (ignored while busy=1)
//  init_ch    in   CW  channel to write
//  init_sel   in   2   0=x 1=y 2=vx 3=vy
//  init_data  in   W   Q-format value
//  step_valid in   1   request one integration step of all channels
//  step_ready out  1   =~busy; step accepted on step_valid&step_ready
//  busy       out  1   step in progress
//  out_valid  out  1   one-cycle pulse per finished channel
//  out_ch     out  CW  channel of out_x/out_y
//  out_x      out  W   updated x of out_ch
//  out_y      out  W   updated y of out_ch
//  div0_flag  out  1   sticky: a channel had |p|^3==0 since last accepted step
//  sat_flag   out  1   sticky saturation flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all x,y,vx,vy=0, FSM=IDLE, busy=0, step_ready=1, out_valid=0, out_ch=0, out_x=out_y=0, flags=0.
//  FSM: IDLE -> SQ -> SQRT -> CUBE -> DIV -> ACC -> VEL -> POS -> EMIT -> (SQ next ch | IDLE).
//   IDLE: on step accept: ch=0, busy=1, div0_flag and sat_flag cleared.
//   SQ (2 cyc): r2 = x*x + y*y, 2W+1-bit unsigned, kept at 2F fraction.
//   SQRT (W cyc): r = floor(sqrt(r2)) restoring bit-serial, result Q.F, W bits unsigned.
//   CUBE (2 cyc): r3 = r2*r >> 2F (Q.F, unsigned, saturating in 2W bits).
//   DIV (W cyc): k = (GM << F) / r3 restoring unsigned; r3==0 -> k=0, div0_flag=1, no stall.
//   ACC (2 cyc): ax = -(x*k)>>>F, ay = -(y*k)>>>F.
//   VEL (2 cyc): vx += (ax*DT)>>>F; vy += (ay*DT)>>>F.
//   POS (2 cyc): x += (vx_new*DT)>>>F; y += (vy_new*DT)>>>F; write back to channel regs.
//   EMIT (1 cyc): out_valid=1, out_ch=ch, out_x/out_y = new x/y (held until next EMIT).
//  Per-channel latency exactly 2W+11 cycles (SQ start to EMIT); step = N_CH*(2W+11) cycles.
//  Channels processed in ascending order; after ch=N_CH-1 EMIT -> IDLE, busy=0 next cycle.
//  Products: full 2W signed, arithmetic right shift by F (floor), then narrowed to W.
//  step_valid while busy: not accepted, no queueing. init_we while busy: dropped.
//  init_we and step accept same cycle in IDLE: write lands first, step uses new value.
//  rst mid-step: immediate return to reset state, partially updated channel discarded.
// CONFIGURATION
//  ORBIT_SAT_EN defined: every narrowing to W and every add saturates to
//   [-2^(W-1), 2^(W-1)-1]; any clamp sets sat_flag (sticky until next step accept).
//  ORBIT_SAT_EN undefined: narrowing/adds wrap two's complement; sat_flag tied 0.
// TESTING
//  T1 circular: x=0x00010000,y=0,vx=0,vy=0x00010000, 1 step -> out_x=0x0000FFF0, out_y=0x00000400, vx=0xFFFFFC00.
//  T2 latency: N_CH=4, accept step -> out_valid on ch0..3 at 75,150,225,300 cycles after accept (W=32); busy low at 301.
//  T3 zero position: ch1 x=y=0,vx=0x400 -> div0_flag=1, ch1 out_x=0x00000010, other channels unaffected.
//  T4 handshake: step_valid and init_we held during busy -> step_ready=0, no extra step, channel regs unchanged.
//  T5 reset mid-step: rst at cycle 100 of step -> next cycle busy=0, out_valid=0, all state reads back 0.
//  T6 overflow: x=0x7FFF0000, vx=0x7FFF0000, DT=0x00010000 -> with ORBIT_SAT_EN out_x=0x7FFFFFFF, sat_flag=1; without, wrapped value, sat_flag=0.

Source files
------------

// File: rtl/orbit_integrator_fx.sv
// orbit_integrator_fx: semi-implicit Euler two-body integrator, N_CH bodies time-multiplexed over one multiplier.
// Optional macro ORBIT_SAT_EN: saturate every narrowing/add to W bits and report clamps on sat_flag.
module orbit_integrator_fx #(
  parameter int           W    = 32,
  parameter int           F    = 16,
  parameter int           N_CH = 4,
  parameter logic [W-1:0] GM   = 32'h00010000,
  parameter logic [W-1:0] DT   = 32'h00000400,
  parameter int           CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_we,
  input  logic [CW-1:0] init_ch,
  input  logic [1:0]    init_sel,
  input  logic [W-1:0]  init_data,
  input  logic          step_valid,
  output logic          step_ready,
  output logic          busy,
  output logic          out_valid,
  output logic [CW-1:0] out_ch,
  output logic [W-1:0]  out_x,
  output logic [W-1:0]  out_y,
  output logic          div0_flag,
  output logic          sat_flag
);
  localparam int NW = 2*W+2;
  localparam int KW = $clog2(W);
  localparam logic [W+F-1:0] NUM = {GM, {F{1'b0}}};
`ifdef ORBIT_SAT_EN
  localparam logic signed [NW-1:0] MAXV = {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [NW-1:0] MINV = {{(W+3){1'b1}}, {(W-1){1'b0}}};
`endif

  typedef enum logic [3:0] {IDLE, SQ, SQRT, CUBE, DIV, ACC, VEL, POS, EMIT} state_t;
  state_t state;

  logic [W-1:0]   px [N_CH], py [N_CH], pvx [N_CH], pvy [N_CH];
  logic [CW-1:0]  ch;
  logic           ph, dskip;
  logic [KW-1:0]  cnt;
  logic [2*W:0]   r2;
  logic [2*W-1:0] r2s, r3, acc;
  logic [W:0]     srem;
  logic [W-1:0]   r, k, dnum, ax, ay;

  // Narrow to W bits; MSB of the result is the clamp indicator.
  function automatic logic [W:0] nar(input logic signed [NW-1:0] v);
`ifdef ORBIT_SAT_EN
    if (v > MAXV) return {1'b1, 1'b0, {(W-1){1'b1}}};
    if (v < MINV) return {1'b1, 1'b1, {(W-1){1'b0}}};
`endif
    return {1'b0, v[W-1:0]};
  endfunction

  function automatic logic [W:0] add_w(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W:0] s;
    s = $signed({a[W-1], a}) + $signed({b[W-1], b});
    return nar({{(W+1){s[W]}}, s});
  endfunction

  function automatic logic signed [W:0] sx(input logic [W-1:0] a);
    return $signed({a[W-1], a});
  endfunction

  logic signed [W:0]    ma, mb;
  logic signed [NW-1:0] mp, mneg;
  logic [W:0]           pn, pneg, upd;
  logic [W-1:0]         base;
  logic [2*W:0]         r2_sum, d_sh;
  logic [W+2:0]         s_sh, s_tr;
  logic [3*W:0]         c_full, c_sh;
  logic [2*W-1:0]       r3_n;

  always_comb begin
    ma = '0;
    mb = '0;
    case (state)
      SQ:   begin ma = sx(ph ? py[ch] : px[ch]); mb = ma; end
      CUBE: begin ma = {1'b0, ph ? r2[2*W-1:W] : r2[W-1:0]}; mb = {1'b0, r}; end
      ACC:  begin ma = sx(ph ? py[ch] : px[ch]); mb = {1'b0, k}; end
      VEL:  begin ma = sx(ph ? ay : ax); mb = sx(DT); end
      POS:  begin ma = sx(ph ? pvy[ch] : pvx[ch]); mb = sx(DT); end
      default: ;
    endcase
    mp     = ma * mb;
    mneg   = -mp;
    pn     = nar(mp >>> F);
    pneg   = nar(mneg >>> F);
    base   = (state == VEL) ? (ph ? pvy[ch] : pvx[ch]) : (ph ? py[ch] : px[ch]);
    upd    = add_w(base, pn[W-1:0]);
    r2_sum = r2 + {1'b0, mp[2*W-1:0]};
    s_sh   = {srem, r2s[2*W-1 -: 2]};
    s_tr   = {1'b0, r, 2'b01};
    d_sh   = {acc, dnum[W-1]};
    // r2*r assembled from two W x W partial products (low half, then high half)
    c_full = {1'b0, mp[2*W-1:0], {W{1'b0}}} + {{(W+1){1'b0}}, acc};
    c_sh   = c_full >> (2*F);
    r3_n   = (r2[2*W] || (|c_sh[3*W:2*W])) ? '1 : c_sh[2*W-1:0];
  end

  assign step_ready = ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; busy <= 1'b0; out_valid <= 1'b0; out_ch <= '0;
      out_x <= '0; out_y <= '0; div0_flag <= 1'b0; sat_flag <= 1'b0;
      ch <= '0; ph <= 1'b0; dskip <= 1'b0; cnt <= '0;
      r2 <= '0; r2s <= '0; r3 <= '0; acc <= '0; srem <= '0;
      r <= '0; k <= '0; dnum <= '0; ax <= '0; ay <= '0;
      for (int i = 0; i < N_CH; i++) begin
        px[i] <= '0; py[i] <= '0; pvx[i] <= '0; pvy[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (init_we)
            case (init_sel)
              2'd0: px[init_ch]  <= init_data;
              2'd1: py[init_ch]  <= init_data;
              2'd2: pvx[init_ch] <= init_data;
              default: pvy[init_ch] <= init_data;
            endcase
          if (step_valid) begin
            state <= SQ; ch <= '0; ph <= 1'b0; busy <= 1'b1;
            div0_flag <= 1'b0; sat_flag <= 1'b0;
          end
        end
        SQ: begin
          ph <= ~ph;
          if (!ph) r2 <= {1'b0, mp[2*W-1:0]};
          else begin
            r2 <= r2_sum;
            r2s <= r2_sum[2*W] ? '1 : r2_sum[2*W-1:0];
            srem <= '0; r <= '0; cnt <= '0; state <= SQRT;
          end
        end
        SQRT: begin
          r2s <= r2s << 2;
          if (s_sh >= s_tr) begin
            srem <= s_sh[W:0] - s_tr[W:0]; r <= {r[W-2:0], 1'b1};
          end else begin
            srem <= s_sh[W:0]; r <= {r[W-2:0], 1'b0};
          end
          cnt <= cnt + KW'(1);
          if (cnt == KW'(W-1)) state <= CUBE;
        end
        CUBE: begin
          ph <= ~ph;
          if (!ph) acc <= mp[2*W-1:0];
          else begin
            r3 <= r3_n; cnt <= '0; state <= DIV;
            acc <= {{(2*W-F){1'b0}}, NUM[W+F-1:W]};
            dnum <= NUM[W-1:0]; k <= '0; dskip <= 1'b0;
            // zero divisor or quotient wider than W: skip iterations but keep the fixed latency
            if (r3_n == '0) begin
              dskip <= 1'b1; div0_flag <= 1'b1;
            end else if ({{(2*W-F){1'b0}}, NUM[W+F-1:W]} >= r3_n) begin
              dskip <= 1'b1; k <= '1;
            end
          end
        end
        DIV: begin
          if (!dskip) begin
            dnum <= dnum << 1;
            if (d_sh >= {1'b0, r3}) begin
              acc <= d_sh[2*W-1:0] - r3; k <= {k[W-2:0], 1'b1};
            end else begin
              acc <= d_sh[2*W-1:0]; k <= {k[W-2:0], 1'b0};
            end
          end
          cnt <= cnt + KW'(1);
          if (cnt == KW'(W-1)) state <= ACC;
        end
        ACC: begin
          ph <= ~ph;
          sat_flag <= sat_flag | pneg[W];
          if (!ph) ax <= pneg[W-1:0];
          else begin ay <= pneg[W-1:0]; state <= VEL; end
        end
        VEL: begin
          ph <= ~ph;
          sat_flag <= sat_flag | pn[W] | upd[W];
          if (!ph) pvx[ch] <= upd[W-1:0];
          else begin pvy[ch] <= upd[W-1:0]; state <= POS; end
        end
        POS: begin
          ph <= ~ph;
          sat_flag <= sat_flag | pn[W] | upd[W];
          if (!ph) px[ch] <= upd[W-1:0];
          else begin
            py[ch] <= upd[W-1:0];
            out_valid <= 1'b1; out_ch <= ch; out_x <= px[ch]; out_y <= upd[W-1:0];
            state <= EMIT;
          end
        end
        EMIT: begin
          if (ch == CW'(N_CH-1)) begin
            state <= IDLE; busy <= 1'b0;
          end else begin
            ch <= ch + CW'(1); state <= SQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_orbit_integrator_fx.sv
// tb_orbit_integrator_fx: directed vectors for the orbit integrator; a second instance (DT=1.0) covers overflow.
`timescale 1ns/1ps
module tb_orbit_integrator_fx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        init_we = 1'b0, step_valid = 1'b0;
  logic [1:0]  init_ch = '0, init_sel = '0;
  logic [31:0] init_data = '0;
  logic        step_ready, busy, out_valid, div0_flag, sat_flag;
  logic [1:0]  out_ch;
  logic [31:0] out_x, out_y;

  logic        we2 = 1'b0, step2 = 1'b0, ch2 = 1'b0;
  logic [1:0]  sel2 = '0;
  logic [31:0] data2 = '0;
  logic        ready2, busy2, valid2, div02, sat2, och2;
  logic [31:0] ox2, oy2;

  orbit_integrator_fx dut (
    .clk(clk), .rst(rst), .init_we(init_we), .init_ch(init_ch), .init_sel(init_sel),
    .init_data(init_data), .step_valid(step_valid), .step_ready(step_ready), .busy(busy),
    .out_valid(out_valid), .out_ch(out_ch), .out_x(out_x), .out_y(out_y),
    .div0_flag(div0_flag), .sat_flag(sat_flag));

  orbit_integrator_fx #(.N_CH(2), .DT(32'h00010000)) dut_ovf (
    .clk(clk), .rst(rst), .init_we(we2), .init_ch(ch2), .init_sel(sel2),
    .init_data(data2), .step_valid(step2), .step_ready(ready2), .busy(busy2),
    .out_valid(valid2), .out_ch(och2), .out_x(ox2), .out_y(oy2),
    .div0_flag(div02), .sat_flag(sat2));

  int checks = 0, fails = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int          n_emit, busy_low, rebusy;
  int          emit_cyc [8];
  logic [31:0] ex [8], ey [8];
  logic [1:0]  ec [8];
  logic [31:0] exp_x [4] = '{32'h0000FFF0, 32'h00000010, 32'h0001FFFC, 32'h00000400};
  logic [31:0] exp_y [4] = '{32'h00000400, 32'h00000000, 32'h00000000, 32'hFFFF0010};

  task automatic wr(input logic [1:0] c, input logic [1:0] s, input logic [31:0] d);
    init_we = 1'b1; init_ch = c; init_sel = s; init_data = d;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic run_step(input int max_cyc, input int drop_at, input bit hold);
    n_emit = 0; busy_low = 0; rebusy = 0;
    step_valid = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (out_valid && n_emit < 8) begin
        emit_cyc[n_emit] = c; ex[n_emit] = out_x; ey[n_emit] = out_y; ec[n_emit] = out_ch;
        n_emit++;
      end
      if (busy && busy_low != 0) rebusy = 1;
      if (!busy && busy_low == 0) busy_low = c;
      if (hold && c == 1) begin
        init_we = 1'b1; init_ch = 2'd0; init_sel = 2'd0; init_data = 32'h12340000;
      end
      if (hold && c == 150) chk("step_ready_busy", step_ready, 0);
      if (c == drop_at) begin step_valid = 1'b0; init_we = 1'b0; end
    end
  endtask

  logic        got_ovf;
  logic [31:0] gx, gy;
  logic [31:0] exp_ovf_x;
  logic        exp_ovf_sat;

  initial begin
`ifdef ORBIT_SAT_EN
    exp_ovf_x = 32'h7FFFFFFF; exp_ovf_sat = 1'b1;
`else
    exp_ovf_x = 32'hFFFE0000; exp_ovf_sat = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ready", step_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_xy", {out_x, out_y}, 0);
    chk("rst_ch_flags", {out_ch, div0_flag, sat_flag}, 0);

    // ch0 circular orbit, ch1 at origin, ch2 at r=2, ch3 at (0,-1) moving +x
    wr(2'd0, 2'd0, 32'h00010000);
    wr(2'd0, 2'd3, 32'h00010000);
    wr(2'd1, 2'd2, 32'h00000400);
    wr(2'd2, 2'd0, 32'h00020000);
    wr(2'd3, 2'd1, 32'hFFFF0000);
    wr(2'd3, 2'd2, 32'h00010000);
    run_step(310, 290, 1'b1);
    chk("emit_count", n_emit, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("emit%0d_cycle", i), emit_cyc[i], 75 * (i + 1));
      chk($sformatf("emit%0d_ch", i), ec[i], i);
      chk($sformatf("emit%0d_x", i), ex[i], exp_x[i]);
      chk($sformatf("emit%0d_y", i), ey[i], exp_y[i]);
    end
    chk("busy_low_cycle", busy_low, 301);
    chk("no_extra_step", rebusy, 0);
    chk("div0_flag", div0_flag, 1);
    chk("sat_flag_step", sat_flag, 0);

    // reset in the middle of a step
    step_valid = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) step_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_xy", {out_x, out_y}, 0);
    chk("midrst_div0", div0_flag, 0);
    run_step(310, 1, 1'b0);
    chk("zero_emit_count", n_emit, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("zero_emit%0d_xy", i), {ex[i], ey[i]}, 0);
    chk("zero_div0", div0_flag, 1);

    // overflow instance: last write and step accept in the same cycle
    we2 = 1'b1; ch2 = 1'b0; sel2 = 2'd0; data2 = 32'h7FFF0000;
    @(negedge clk);
    sel2 = 2'd2; step2 = 1'b1;
    @(negedge clk);
    we2 = 1'b0; step2 = 1'b0;
    got_ovf = 1'b0; gx = '0; gy = '0;
    for (int c = 2; c <= 200; c++) begin
      @(negedge clk);
      if (valid2 && och2 == 1'b0 && !got_ovf) begin got_ovf = 1'b1; gx = ox2; gy = oy2; end
    end
    chk("ovf_emit", got_ovf, 1);
    chk("ovf_x", gx, exp_ovf_x);
    chk("ovf_y", gy, 0);
    chk("ovf_sat", sat2, exp_ovf_sat);
    chk("ovf_busy", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
